// File: rtl/sha256_nonce_feeder.sv
// sha256_nonce_feeder
// Work-issue stage ahead of the 64-round SHA-256 compression pipeline.
// Takes one mining job (midstate + 96-bit header tail + nonce range), sweeps
// the nonce range one block per cycle, and carries each issued nonce down a
// LATENCY-deep tag line so it lines up with the pipeline's hash output.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   job_*               job handshake (job_valid/job_ready) and job payload
//   hold                pause issuing for the next cycle
//   abort               drop the current job and all in-flight tags
//   tx_valid/tx_w/      padded second-chunk block and initial hash
//   tx_initial_h          presented to the pipeline
//   tag_valid/tag_nonce nonce belonging to the hash the pipeline presents now
//   busy                feeder not idle
//   done                one-cycle pulse alongside the job's final tag
module sha256_nonce_feeder #(
  parameter int unsigned LATENCY = 65
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [255:0] job_midstate,
  input  logic [95:0]  job_tail,
  input  logic [31:0]  job_nonce_start,
  input  logic [31:0]  job_nonce_end,
  input  logic         hold,
  input  logic         abort,
  output logic         tx_valid,
  output logic [511:0] tx_w,
  output logic [255:0] tx_initial_h,
  output logic         tag_valid,
  output logic [31:0]  tag_nonce,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_e;

  state_e state_q, state_d;

  logic [255:0] mid_q, mid_d;
  logic [95:0]  tail_q, tail_d;
  logic [31:0]  end_q, end_d;
  logic [31:0]  cur_q, cur_d;

  logic         tx_valid_q, tx_valid_d;
  logic [511:0] tx_w_q, tx_w_d;
  logic [255:0] tx_h_q, tx_h_d;
  logic         tx_last_q, tx_last_d;

  // The tag line is fed from the tx registers, so an entry leaves the line
  // exactly LATENCY cycles after its block was presented on tx_*.
  // tag_last is only ever set together with tag_vld, which lets done come
  // straight from a flop.
  logic [LATENCY-1:0]       tag_vld_q, tag_vld_d;
  logic [LATENCY-1:0]       tag_last_q, tag_last_d;
  logic [LATENCY-1:0][31:0] tag_nonce_q, tag_nonce_d;

  logic job_ready_q, job_ready_d;
  logic busy_q, busy_d;

  logic flush;

  always_comb begin
    state_d    = state_q;
    mid_d      = mid_q;
    tail_d     = tail_q;
    end_d      = end_q;
    cur_d      = cur_q;
    tx_valid_d = 1'b0;
    tx_w_d     = tx_w_q;
    tx_h_d     = tx_h_q;
    tx_last_d  = 1'b0;
    flush      = 1'b0;

    case (state_q)
      IDLE: begin
        if (job_valid) begin
          mid_d   = job_midstate;
          tail_d  = job_tail;
          end_d   = job_nonce_end;
          cur_d   = job_nonce_start;
          state_d = SWEEP;
        end
      end
      SWEEP: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = IDLE;
        end else if (!hold) begin
          tx_valid_d = 1'b1;
          tx_w_d     = {tail_q, cur_q, 32'h8000_0000, 320'b0, 32'h0000_0280};
          tx_h_d     = mid_q;
          tx_last_d  = (cur_q == end_q);
          if (cur_q == end_q) state_d = DRAIN;
          else                cur_d   = cur_q + 32'd1;
        end
      end
      DRAIN: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = IDLE;
        end else if (tag_last_q[LATENCY-1]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    tag_vld_d[0]   = tx_valid_q;
    tag_last_d[0]  = tx_last_q;
    tag_nonce_d[0] = tx_w_q[415:384];
    for (int unsigned i = 1; i < LATENCY; i++) begin
      tag_vld_d[i]   = tag_vld_q[i-1];
      tag_last_d[i]  = tag_last_q[i-1];
      tag_nonce_d[i] = tag_nonce_q[i-1];
    end
    if (flush) begin
      tag_vld_d  = '0;
      tag_last_d = '0;
    end

    job_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mid_q       <= '0;
      tail_q      <= '0;
      end_q       <= '0;
      cur_q       <= '0;
      tx_valid_q  <= 1'b0;
      tx_w_q      <= '0;
      tx_h_q      <= '0;
      tx_last_q   <= 1'b0;
      tag_vld_q   <= '0;
      tag_last_q  <= '0;
      tag_nonce_q <= '0;
      job_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mid_q       <= mid_d;
      tail_q      <= tail_d;
      end_q       <= end_d;
      cur_q       <= cur_d;
      tx_valid_q  <= tx_valid_d;
      tx_w_q      <= tx_w_d;
      tx_h_q      <= tx_h_d;
      tx_last_q   <= tx_last_d;
      tag_vld_q   <= tag_vld_d;
      tag_last_q  <= tag_last_d;
      tag_nonce_q <= tag_nonce_d;
      job_ready_q <= job_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign job_ready    = job_ready_q;
  assign busy         = busy_q;
  assign tx_valid     = tx_valid_q;
  assign tx_w         = tx_w_q;
  assign tx_initial_h = tx_h_q;
  assign tag_valid    = tag_vld_q[LATENCY-1];
  assign tag_nonce    = tag_nonce_q[LATENCY-1];
  assign done         = tag_last_q[LATENCY-1];

endmodule
